// File: rtl/scaled_clock_gen.sv
// Runtime-programmable clock divider producing a square or pulse output plus a period tick.
// Optional SCALEDCLK_SYNC_EN adds a sync_in port that realigns the period to an external edge.
module scaled_clock_gen #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             clock,
  input  logic             reset,
`ifdef SCALEDCLK_SYNC_EN
  input  logic             sync_in,
`endif
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  input  logic             mode,
  output logic             div_pending,
  output logic             scaledclk,
  output logic             tick,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] counter, counter_nx;
  logic [WIDTH-1:0] period, period_nx;
  logic [WIDTH-1:0] pending, pending_nx;
  logic [WIDTH-1:0] load_val;
  logic             pend_r, pend_nx;
  logic             mode_r, mode_nx;
  logic             sclk_r, sclk_nx;
  logic             tick_r, tick_nx;
  logic             wrap, realign, apply;

`ifdef SCALEDCLK_SYNC_EN
  // Two-flop synchroniser followed by an edge-detect register; realign is the
  // synchronised rising edge and acts on the third clock edge after sync_in rises.
  logic sync_ff1, sync_ff2, sync_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_ff1  <= 1'b0;
      sync_ff2  <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_ff1  <= sync_in;
      sync_ff2  <= sync_ff1;
      sync_prev <= sync_ff2;
    end
  end

  assign realign = sync_ff2 & ~sync_prev;
`else
  assign realign = 1'b0;
`endif

  always_comb begin
    wrap     = enable && (counter == (period - WIDTH'(1)));
    apply    = wrap || realign;
    load_val = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;

    counter_nx = counter;
    if (realign)     counter_nx = '0;
    else if (enable) counter_nx = wrap ? '0 : counter + WIDTH'(1);

    // A load on the boundary edge supersedes the older pending value, so nothing is applied.
    period_nx  = (apply && pend_r && !div_load) ? pending : period;
    pending_nx = div_load ? load_val : pending;
    pend_nx    = div_load ? 1'b1 : (apply ? 1'b0 : pend_r);
    mode_nx    = apply ? mode : mode_r;
    tick_nx    = wrap && !realign;

    sclk_nx = sclk_r;
    if (realign)      sclk_nx = 1'b0;
    else if (enable)  sclk_nx = mode_nx ? wrap : (counter_nx >= (period_nx >> 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter <= '0;
      period  <= WIDTH'(DEFAULT_DIV);
      pending <= '0;
      pend_r  <= 1'b0;
      mode_r  <= 1'b0;
      sclk_r  <= 1'b0;
      tick_r  <= 1'b0;
    end else begin
      counter <= counter_nx;
      period  <= period_nx;
      pending <= pending_nx;
      pend_r  <= pend_nx;
      mode_r  <= mode_nx;
      sclk_r  <= sclk_nx;
      tick_r  <= tick_nx;
    end
  end

  assign count       = counter;
  assign div_pending = pend_r;
  assign scaledclk   = sclk_r;
  assign tick        = tick_r;

endmodule

// File: tb/tb_scaled_clock_gen.sv
// Directed bench for scaled_clock_gen: long P=100 sequences, a per-cycle vector table
// for clamp/load/mode/enable corners, async reset, and sync realign when enabled.
module tb_scaled_clock_gen;

  localparam int WIDTH = 16;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             mode;
  logic             div_pending;
  logic             scaledclk;
  logic             tick;
  logic [WIDTH-1:0] count;
`ifdef SCALEDCLK_SYNC_EN
  logic             sync_in;
`endif

  scaled_clock_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(100)) dut (
    .clock       (clock),
    .reset       (reset),
`ifdef SCALEDCLK_SYNC_EN
    .sync_in     (sync_in),
`endif
    .enable      (enable),
    .div_in      (div_in),
    .div_load    (div_load),
    .mode        (mode),
    .div_pending (div_pending),
    .scaledclk   (scaledclk),
    .tick        (tick),
    .count       (count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int errors = 0;
  int checks = 0;
  int exp_cnt;
  int since_tick;
  int last_period;
  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic             en;
    logic             ld;
    logic [WIDTH-1:0] din;
    logic             md;
    logic [WIDTH-1:0] cnt;
    logic             sclk;
    logic             tk;
    logic             pend;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One active edge, then sample on the falling edge; tracks tick-to-tick spacing.
  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
    since_tick++;
    if (tick === 1'b1) begin
      last_period = since_tick;
      since_tick  = 0;
    end
  endtask

  // Square-mode reference: count wraps at p-1, tick at count 0, high for count >= p/2.
  task automatic run_check(input int n, input int p, input logic pend);
    logic [WIDTH-1:0] e;
    int c;
    c = exp_cnt;
    for (int i = 0; i < n; i++) begin
      c = (c == p - 1) ? 0 : c + 1;
      exp_q.push_back(WIDTH'(c));
    end
    for (int i = 0; i < n; i++) begin
      cycle();
      e = exp_q.pop_front();
      check("count", count, e);
      check("tick", tick, (e == 0));
      check("scaledclk", scaledclk, (int'(e) >= p / 2));
      check("div_pending", div_pending, pend);
    end
    exp_cnt = c;
  endtask

  task automatic add_vec(input logic en, input logic ld, input int din, input logic md,
                         input int cnt, input logic sclk, input logic tk, input logic pend);
    vec_t v;
    v.en = en; v.ld = ld; v.din = WIDTH'(din); v.md = md;
    v.cnt = WIDTH'(cnt); v.sclk = sclk; v.tk = tk; v.pend = pend;
    vq.push_back(v);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    div_in   = '0;
    div_load = 1'b0;
    mode     = 1'b0;
`ifdef SCALEDCLK_SYNC_EN
    sync_in  = 1'b0;
`endif
    since_tick  = 0;
    last_period = 0;
    exp_cnt     = 0;

    // Starting at P=5, count 0: clamp 0 and 1 to 2, load-on-wrap, mode change mid-period,
    // enable low holding a pulse-mode output.
    //      en ld din md  cnt sclk tick pend
    add_vec(1, 1, 0,  0,  1,  0,   0,   1);
    add_vec(1, 1, 1,  0,  2,  1,   0,   1);
    add_vec(1, 0, 0,  0,  3,  1,   0,   1);
    add_vec(1, 0, 0,  0,  4,  1,   0,   1);
    add_vec(1, 0, 0,  0,  0,  0,   1,   0);
    add_vec(1, 0, 0,  0,  1,  1,   0,   0);
    add_vec(1, 0, 0,  0,  0,  0,   1,   0);
    add_vec(1, 0, 0,  0,  1,  1,   0,   0);
    add_vec(1, 1, 10, 0,  0,  0,   1,   1);
    add_vec(1, 0, 0,  0,  1,  1,   0,   1);
    add_vec(1, 0, 0,  0,  0,  0,   1,   0);
    add_vec(1, 0, 0,  0,  1,  0,   0,   0);
    add_vec(1, 0, 0,  0,  2,  0,   0,   0);
    add_vec(1, 0, 0,  1,  3,  0,   0,   0);
    add_vec(1, 0, 0,  1,  4,  0,   0,   0);
    add_vec(1, 0, 0,  1,  5,  1,   0,   0);
    add_vec(1, 0, 0,  1,  6,  1,   0,   0);
    add_vec(1, 0, 0,  1,  7,  1,   0,   0);
    add_vec(1, 0, 0,  1,  8,  1,   0,   0);
    add_vec(1, 0, 0,  1,  9,  1,   0,   0);
    add_vec(1, 0, 0,  1,  0,  1,   1,   0);
    add_vec(0, 0, 0,  1,  0,  1,   0,   0);
    add_vec(0, 0, 0,  1,  0,  1,   0,   0);
    add_vec(1, 0, 0,  1,  1,  0,   0,   0);
    for (int k = 2; k <= 9; k++) add_vec(1, 0, 0, 1, k, 0, 0, 0);
    add_vec(1, 0, 0,  1,  0,  1,   1,   0);
    add_vec(1, 0, 0,  0,  1,  0,   0,   0);

    // reset state
    #12;
    check("rst_count", count, 0);
    check("rst_scaledclk", scaledclk, 0);
    check("rst_tick", tick, 0);
    check("rst_div_pending", div_pending, 0);

    @(negedge clock);
    reset  = 1'b0;
    enable = 1'b1;

    // default period: first tick after 100 edges
    run_check(130, 100, 1'b0);
    check("first_period", last_period, 100);

    // enable low for 7 cycles at count 30
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      check("hold_count", count, 30);
      check("hold_tick", tick, 0);
      check("hold_scaledclk", scaledclk, 0);
    end
    enable = 1'b1;
    run_check(70, 100, 1'b0);
    check("stretched_period", last_period, 107);

    // load 5 at count 40; applied at the wrap after count 99
    run_check(40, 100, 1'b0);
    div_in   = WIDTH'(5);
    div_load = 1'b1;
    run_check(1, 100, 1'b1);
    div_load = 1'b0;
    div_in   = '0;
    run_check(58, 100, 1'b1);
    check("pre_wrap_count", count, 99);
    cycle();
    check("p5_wrap_count", count, 0);
    check("p5_wrap_tick", tick, 1);
    check("p5_wrap_scaledclk", scaledclk, 0);
    check("p5_wrap_pending", div_pending, 0);
    exp_cnt = 0;
    run_check(10, 5, 1'b0);
    check("p5_period", last_period, 5);

    // vector table
    for (int i = 0; i < vq.size(); i++) begin
      enable   = vq[i].en;
      div_load = vq[i].ld;
      div_in   = vq[i].din;
      mode     = vq[i].md;
      cycle();
      check($sformatf("vec%0d_count", i), count, vq[i].cnt);
      check($sformatf("vec%0d_scaledclk", i), scaledclk, vq[i].sclk);
      check($sformatf("vec%0d_tick", i), tick, vq[i].tk);
      check($sformatf("vec%0d_pending", i), div_pending, vq[i].pend);
    end
    div_load = 1'b0;
    div_in   = '0;
    mode     = 1'b0;
    enable   = 1'b1;

    // async reset with a divisor pending; pending value must be lost
    div_in   = WIDTH'(7);
    div_load = 1'b1;
    cycle();
    div_load = 1'b0;
    cycle();
    cycle();
    check("pre_reset_count", count, 4);
    check("pre_reset_pending", div_pending, 1);
    #2 reset = 1'b1;
    #1;
    check("async_count", count, 0);
    check("async_pending", div_pending, 0);
    check("async_tick", tick, 0);
    check("async_scaledclk", scaledclk, 0);
    @(negedge clock);
    reset      = 1'b0;
    since_tick = 0;
    exp_cnt    = 0;
    run_check(100, 100, 1'b0);
    check("post_reset_period", last_period, 100);

`ifdef SCALEDCLK_SYNC_EN
    // sync pulse at count 37 realigns on the third edge without a tick
    run_check(37, 100, 1'b0);
    sync_in = 1'b1;
    cycle();
    check("sync_e1_count", count, 38);
    cycle();
    check("sync_e2_count", count, 39);
    cycle();
    check("sync_e3_count", count, 0);
    check("sync_e3_scaledclk", scaledclk, 0);
    check("sync_e3_tick", tick, 0);
    sync_in = 1'b0;
    exp_cnt = 0;
    run_check(5, 100, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
